// File: rtl/controle_jogo_pkg.sv
// Shared game definitions: state encoding, default round parameters and
// small helpers used by the round controller and the display driver.
package controle_jogo_pkg;

  localparam int unsigned MAX_TENT_PADRAO   = 5;
  localparam int unsigned T_FEEDBACK_PADRAO = 8;

  localparam int unsigned TENT_W   = 3;
  localparam int unsigned PONTOS_W = 4;
  localparam int unsigned TIMER_W  = 8;

  localparam logic [PONTOS_W-1:0] PONTOS_MAX = PONTOS_W'(15);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    JOGANDO  = 3'd1,
    AVALIA   = 3'd2,
    FEEDBACK = 3'd3,
    VITORIA  = 3'd4,
    DERROTA  = 3'd5
  } estado_t;

  typedef enum logic [1:0] {
    RES_IGUAL   = 2'd0,
    RES_PERTO   = 2'd1,
    RES_LONGE   = 2'd2,
    RES_NENHUM  = 2'd3
  } resultado_t;

  // Comparator priority: igual wins over ate3, ate3 over errada.
  function automatic resultado_t classifica(input logic igual,
                                            input logic ate3,
                                            input logic errada);
    if (igual)       return RES_IGUAL;
    else if (ate3)   return RES_PERTO;
    else if (errada) return RES_LONGE;
    else             return RES_NENHUM;
  endfunction

  function automatic logic [PONTOS_W-1:0] soma_sat(input logic [PONTOS_W-1:0] p);
    return (p == PONTOS_MAX) ? p : p + PONTOS_W'(1);
  endfunction

endpackage

// File: rtl/controle_jogo_detector_borda.sv
// One-bit rising-edge detector; the edge pulse is combinational from the
// current level and the registered previous level.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic borda_c
);

  logic ant_q;
  logic ant_d;

  always_comb begin
    ant_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ant_q <= 1'b0;
    else        ant_q <= ant_d;
  end

  assign borda_c = d & ~ant_q;

endmodule

// File: rtl/controle_jogo.sv
// Guessing-game round controller: attempts, hot/cold feedback window,
// win/loss reporting and a saturating score.
module controle_jogo
  import controle_jogo_pkg::*;
#(
  parameter int unsigned MAX_TENT   = MAX_TENT_PADRAO,
  parameter int unsigned T_FEEDBACK = T_FEEDBACK_PADRAO
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic       igual,
  input  logic       ate3,
  input  logic       errada,
  output logic       jogando,
  output logic       trava_entrada,
  output logic       quente,
  output logic       frio,
  output logic       vitoria,
  output logic       derrota,
  output logic [2:0] tentativas,
  output logic [3:0] pontos
);

  logic inicio_c;
  logic confirma_c;

  detector_borda u_borda_iniciar (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (iniciar),
    .borda_c (inicio_c)
  );

  detector_borda u_borda_confirmar (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (confirmar),
    .borda_c (confirma_c)
  );

  estado_t               estado_q,  estado_d;
  logic [TENT_W-1:0]     tent_q,    tent_d;
  logic [PONTOS_W-1:0]   pontos_q,  pontos_d;
  logic [TIMER_W-1:0]    timer_q,   timer_d;
  logic                  quente_q,  quente_d;
  logic                  frio_q,    frio_d;
  logic                  jogando_q, jogando_d;
  logic                  trava_q,   trava_d;
  logic                  vitoria_q, vitoria_d;
  logic                  derrota_q, derrota_d;

  resultado_t            res_c;
  logic [TENT_W-1:0]     tent_menos_c;

  always_comb begin
    res_c        = classifica(igual, ate3, errada);
    tent_menos_c = (tent_q == '0) ? '0 : tent_q - TENT_W'(1);
  end

  // Next-state, counters and registered outputs derived from the next state.
  always_comb begin
    estado_d = estado_q;
    tent_d   = tent_q;
    pontos_d = pontos_q;
    timer_d  = timer_q;
    quente_d = quente_q;
    frio_d   = frio_q;

    case (estado_q)
      OCIOSO, VITORIA, DERROTA: begin
        if (inicio_c) begin
          estado_d = JOGANDO;
          tent_d   = TENT_W'(MAX_TENT);
          quente_d = 1'b0;
          frio_d   = 1'b0;
        end
      end

      JOGANDO: begin
        if (confirma_c) estado_d = AVALIA;
      end

      AVALIA: begin
        if (res_c == RES_IGUAL) begin
          estado_d = VITORIA;
          pontos_d = soma_sat(pontos_q);
        end else begin
          tent_d = tent_menos_c;
          if (tent_menos_c == '0) begin
            estado_d = DERROTA;
          end else begin
            estado_d = FEEDBACK;
            timer_d  = TIMER_W'(T_FEEDBACK - 1);
            quente_d = (res_c == RES_PERTO);
            frio_d   = (res_c != RES_PERTO);
          end
        end
      end

      FEEDBACK: begin
        if (timer_q == '0) begin
          estado_d = JOGANDO;
          quente_d = 1'b0;
          frio_d   = 1'b0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      default: begin
        estado_d = OCIOSO;
        quente_d = 1'b0;
        frio_d   = 1'b0;
      end
    endcase

    jogando_d = (estado_d == JOGANDO) || (estado_d == AVALIA) ||
                (estado_d == FEEDBACK);
    trava_d   = (estado_d != JOGANDO);
    vitoria_d = (estado_d == VITORIA);
    derrota_d = (estado_d == DERROTA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      tent_q    <= '0;
      pontos_q  <= '0;
      timer_q   <= '0;
      quente_q  <= 1'b0;
      frio_q    <= 1'b0;
      jogando_q <= 1'b0;
      trava_q   <= 1'b1;
      vitoria_q <= 1'b0;
      derrota_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      tent_q    <= tent_d;
      pontos_q  <= pontos_d;
      timer_q   <= timer_d;
      quente_q  <= quente_d;
      frio_q    <= frio_d;
      jogando_q <= jogando_d;
      trava_q   <= trava_d;
      vitoria_q <= vitoria_d;
      derrota_q <= derrota_d;
    end
  end

  assign jogando       = jogando_q;
  assign trava_entrada = trava_q;
  assign quente        = quente_q;
  assign frio          = frio_q;
  assign vitoria       = vitoria_q;
  assign derrota       = derrota_q;
  assign tentativas    = tent_q;
  assign pontos        = pontos_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo with default parameters (5 attempts,
// 8-cycle feedback window).
module tb_controle_jogo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iniciar, confirmar, igual, ate3, errada;
  logic       jogando, trava_entrada, quente, frio, vitoria, derrota;
  logic [2:0] tentativas;
  logic [3:0] pontos;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  controle_jogo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .iniciar       (iniciar),
    .confirmar     (confirmar),
    .igual         (igual),
    .ate3          (ate3),
    .errada        (errada),
    .jogando       (jogando),
    .trava_entrada (trava_entrada),
    .quente        (quente),
    .frio          (frio),
    .vitoria       (vitoria),
    .derrota       (derrota),
    .tentativas    (tentativas),
    .pontos        (pontos)
  );

  task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inicia_rodada();
    iniciar = 1'b1;
    tick();
    checa("start_jogando", 32'(jogando), 1);
    checa("start_trava", 32'(trava_entrada), 0);
    checa("start_tent", 32'(tentativas), 5);
    checa("start_qf", 32'({quente, frio}), 0);
    iniciar = 1'b0;
    tick();
  endtask

  // Confirm pulse; returns one sample after the result edge.
  task automatic palpite(input logic ig, input logic a3, input logic er);
    igual = ig; ate3 = a3; errada = er;
    confirmar = 1'b1;
    tick();
    checa("avalia_trava", 32'(trava_entrada), 1);
    checa("avalia_sem_res", 32'({vitoria, derrota, quente, frio}), 0);
    confirmar = 1'b0;
    tick();
    igual = 1'b0; ate3 = 1'b0; errada = 1'b0;
  endtask

  // Counts remaining cycles of the hot/cold window, bounded.
  task automatic espera_fb(output int ciclos);
    ciclos = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (quente || frio) ciclos++;
      else break;
    end
    if (quente || frio) checa("fb_timeout", 32'({quente, frio}), 0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    iniciar = 1'b0; confirmar = 1'b0; igual = 1'b0; ate3 = 1'b0; errada = 1'b0;
    #23;
    checa("rst_trava", 32'(trava_entrada), 1);
    checa("rst_outs", 32'({jogando, quente, frio, vitoria, derrota}), 0);
    checa("rst_tent", 32'(tentativas), 0);
    checa("rst_pontos", 32'(pontos), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Win on first guess.
    inicia_rodada();
    palpite(1'b1, 1'b0, 1'b0);
    checa("win_vitoria", 32'(vitoria), 1);
    checa("win_pontos", 32'(pontos), 1);
    checa("win_tent", 32'(tentativas), 5);
    checa("win_jogando", 32'(jogando), 0);

    // Four misses with feedback, fifth is a loss.
    inicia_rodada();
    for (int i = 1; i <= 4; i++) begin
      palpite(1'b0, 1'b0, 1'b1);
      checa("miss_frio", 32'({quente, frio}), 1);
      checa("miss_tent", 32'(tentativas), 32'(5 - i));
      espera_fb(c);
      checa("miss_fb_len", 32'(c), 8);
      checa("miss_volta", 32'(trava_entrada), 0);
    end
    palpite(1'b0, 1'b0, 1'b1);
    checa("loss_derrota", 32'(derrota), 1);
    checa("loss_tent", 32'(tentativas), 0);
    checa("loss_qf", 32'({quente, frio}), 0);
    confirmar = 1'b1; tick(); confirmar = 1'b0; tick(); tick();
    checa("loss_hold", 32'({derrota, tentativas}), 32'({1'b1, 3'd0}));

    // Priority and no-input cases.
    inicia_rodada();
    palpite(1'b0, 1'b1, 1'b1);
    checa("prio_quente", 32'({quente, frio}), 2);
    espera_fb(c);
    palpite(1'b0, 1'b0, 1'b0);
    checa("none_frio", 32'({quente, frio}), 1);
    checa("none_tent", 32'(tentativas), 3);
    espera_fb(c);

    // Held confirm gives one decrement.
    errada = 1'b1;
    confirmar = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    confirmar = 1'b0; errada = 1'b0;
    tick();
    checa("held_tent", 32'(tentativas), 2);
    checa("held_jogando", 32'({jogando, trava_entrada}), 2);

    // Extra confirm and iniciar pulses during feedback are dropped.
    palpite(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      confirmar = 1'b1; iniciar = (i == 1); errada = 1'b1; tick();
      confirmar = 1'b0; iniciar = 1'b0; errada = 1'b0; tick();
    end
    espera_fb(c);
    tick(); tick();
    checa("extra_tent", 32'(tentativas), 1);
    checa("extra_estado", 32'({jogando, trava_entrada, derrota}), 32'(3'b100));

    // Reset in the middle of feedback is asynchronous.
    palpite(1'b0, 1'b0, 1'b1);
    checa("last_derrota", 32'(derrota), 1);
    inicia_rodada();
    palpite(1'b0, 1'b0, 1'b1);
    tick(); tick();
    checa("pre_rst_frio", 32'(frio), 1);
    #2 rst_n = 1'b0;
    #1;
    checa("arst_outs", 32'({jogando, quente, frio, vitoria, derrota}), 0);
    checa("arst_trava", 32'(trava_entrada), 1);
    checa("arst_tent", 32'(tentativas), 0);
    checa("arst_pontos", 32'(pontos), 0);

    // iniciar held across reset release gives exactly one start.
    iniciar = 1'b1;
    tick();
    #2 rst_n = 1'b1;
    tick();
    checa("rel_jogando", 32'(jogando), 1);
    checa("rel_tent", 32'(tentativas), 5);
    tick(); tick();
    iniciar = 1'b0;
    tick();

    // Score saturation over 16 wins.
    for (int i = 1; i <= 16; i++) begin
      palpite(1'b1, 1'b0, 1'b0);
      checa("sat_pontos", 32'(pontos), (i > 15) ? 15 : i);
      inicia_rodada();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
